// File: rtl/framing_encoding_pkg.sv
// Shared constants and state encoding for the frame serializer and its companion blocks.
package framing_encoding_pkg;

    localparam int         PREAMBLE_BITS   = 32;
    localparam logic [7:0] SFD_BYTE        = 8'hA7;
    localparam int         MAX_FRAME_BYTES = 128;
    localparam int         LEN_BITS        = 7;
    localparam int         PTR_W           = LEN_BITS + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA
    } state_t;

endpackage

// File: rtl/framing_encoding_buffer.sv
// 128x8 frame store: one synchronous write port, one asynchronous read port, array not reset.
module framing_buffer
    import framing_encoding_pkg::*;
(
    input  logic                clk,
    input  logic                wr_en,
    input  logic [LEN_BITS-1:0] wr_addr,
    input  logic [7:0]          wr_data,
    input  logic [LEN_BITS-1:0] rd_addr,
    output logic [7:0]          rd_data
);

    logic [7:0] mem [MAX_FRAME_BYTES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/framing_encoding.sv
// Frame serializer: buffers PHR+PSDU bytes, emits preamble, SFD, PHR and PSDU LSB first, one bit per clock.
module framing_encoding
    import framing_encoding_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] phr_psdu_in,
    input  logic       phr_psdu_in_valid,
    output logic       framing_encoding_out,
    output logic       framing_encoding_out_valid
);

    localparam logic [4:0] PRE_LAST  = 5'(PREAMBLE_BITS - 1);
    localparam logic [4:0] BYTE_LAST = 5'd7;

    state_t              state;
    logic [4:0]          bit_cnt;
    logic [LEN_BITS-1:0] byte_idx;
    logic [LEN_BITS-1:0] len_q;
    logic [PTR_W-1:0]    wr_ptr;
    logic [LEN_BITS-1:0] rd_addr;
    logic [7:0]          rd_data;
    logic [7:0]          shift_q;
    logic [7:0]          load_val;
    logic [PTR_W-1:0]    need_cnt;
    logic                wr_en;
    logic                load_en;
    logic                frame_end;

    // Bytes past the 128th are dropped: the pointer saturates at its MSB.
    assign wr_en     = phr_psdu_in_valid && !wr_ptr[PTR_W-1];
    assign rd_addr   = (state == ST_DATA) ? byte_idx + 1'b1 : '0;
    assign need_cnt  = {1'b0, rd_addr};
    assign frame_end = (byte_idx == len_q) || (need_cnt >= wr_ptr);

    framing_buffer u_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[LEN_BITS-1:0]),
        .wr_data (phr_psdu_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        load_en  = 1'b0;
        load_val = rd_data;
        case (state)
            ST_PREAMBLE: begin
                load_en  = (bit_cnt == PRE_LAST);
                load_val = SFD_BYTE;
            end
            ST_SFD:  load_en = (bit_cnt == BYTE_LAST);
            ST_DATA: load_en = (bit_cnt == BYTE_LAST) && !frame_end;
            default: load_en = 1'b0;
        endcase
    end

    // Serializing shift register is pure data and carries no reset.
    always_ff @(posedge clk) begin
        shift_q <= load_en ? (load_val >> 1) : (shift_q >> 1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                      <= ST_IDLE;
            bit_cnt                    <= '0;
            byte_idx                   <= '0;
            len_q                      <= '0;
            wr_ptr                     <= '0;
            framing_encoding_out       <= 1'b0;
            framing_encoding_out_valid <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (phr_psdu_in_valid) begin
                        state                      <= ST_PREAMBLE;
                        bit_cnt                    <= '0;
                        len_q                      <= phr_psdu_in[LEN_BITS-1:0];
                        framing_encoding_out       <= 1'b0;
                        framing_encoding_out_valid <= 1'b1;
                    end
                end
                ST_PREAMBLE: begin
                    if (bit_cnt == PRE_LAST) begin
                        state                <= ST_SFD;
                        bit_cnt              <= '0;
                        framing_encoding_out <= SFD_BYTE[0];
                    end else begin
                        bit_cnt              <= bit_cnt + 1'b1;
                        framing_encoding_out <= 1'b0;
                    end
                end
                ST_SFD: begin
                    if (bit_cnt == BYTE_LAST) begin
                        state                <= ST_DATA;
                        bit_cnt              <= '0;
                        byte_idx             <= '0;
                        framing_encoding_out <= rd_data[0];
                    end else begin
                        bit_cnt              <= bit_cnt + 1'b1;
                        framing_encoding_out <= shift_q[0];
                    end
                end
                ST_DATA: begin
                    if (bit_cnt == BYTE_LAST) begin
                        bit_cnt <= '0;
                        if (frame_end) begin
                            // Covers both normal completion and underrun abort.
                            state                      <= ST_IDLE;
                            byte_idx                   <= '0;
                            wr_ptr                     <= '0;
                            framing_encoding_out       <= 1'b0;
                            framing_encoding_out_valid <= 1'b0;
                        end else begin
                            byte_idx             <= byte_idx + 1'b1;
                            framing_encoding_out <= rd_data[0];
                        end
                    end else begin
                        bit_cnt              <= bit_cnt + 1'b1;
                        framing_encoding_out <= shift_q[0];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_framing_encoding.sv
// Directed bench for framing_encoding: table of burst patterns plus reset corner sequences.
module tb_framing_encoding;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] phr_psdu_in;
    logic       phr_psdu_in_valid;
    logic       framing_encoding_out;
    logic       framing_encoding_out_valid;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [7:0]  mask;
        logic [63:0] bytes;
        int          exp_vld;
    } vec_t;

    vec_t vecs [7];
    bit   cap  [256];
    bit   expb [256];
    int   exp_len;

    always #5 clk = ~clk;

    framing_encoding dut (
        .clk                        (clk),
        .reset_n                    (reset_n),
        .phr_psdu_in                (phr_psdu_in),
        .phr_psdu_in_valid          (phr_psdu_in_valid),
        .framing_encoding_out       (framing_encoding_out),
        .framing_encoding_out_valid (framing_encoding_out_valid)
    );

    function automatic vec_t mk(input string nm, input logic [7:0] m,
                                input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3,
                                input logic [7:0] b4, input logic [7:0] b5,
                                input logic [7:0] b6, input logic [7:0] b7,
                                input int e);
        vec_t v;
        v.name    = nm;
        v.mask    = m;
        v.bytes   = {b7, b6, b5, b4, b3, b2, b1, b0};
        v.exp_vld = e;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected frame from the frame definition: bytes captured on valid cycles, length from PHR[6:0].
    task automatic build_exp(input vec_t v);
        logic [7:0] sfd;
        logic [7:0] wr [8];
        int nw, len, nx;
        sfd     = 8'hA7;
        exp_len = 0;
        nw      = 0;
        for (int i = 0; i < 32; i++) expb[exp_len++] = 1'b0;
        for (int i = 0; i < 8; i++)  expb[exp_len++] = sfd[i];
        for (int c = 0; c < 8; c++) begin
            if (v.mask[c]) wr[nw++] = v.bytes[8*c +: 8];
        end
        len = int'(wr[0][6:0]);
        nx  = (len + 1 < nw) ? len + 1 : nw;
        for (int k = 0; k < nx; k++) begin
            for (int i = 0; i < 8; i++) expb[exp_len++] = wr[k][i];
        end
    endtask

    task automatic run_frame(input vec_t v);
        int vcnt, first, zviol, mism;
        bit done;
        vcnt  = 0;
        first = -1;
        zviol = 0;
        mism  = -1;
        done  = 1'b0;
        build_exp(v);
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk);
            #1;
            if (c < 8) begin
                phr_psdu_in_valid = v.mask[c];
                phr_psdu_in       = v.bytes[8*c +: 8];
            end else begin
                phr_psdu_in_valid = 1'b0;
                phr_psdu_in       = 8'h00;
            end
            @(negedge clk);
            if (framing_encoding_out_valid === 1'b1) begin
                if (first < 0) first = c;
                if (vcnt < 256) cap[vcnt] = framing_encoding_out;
                vcnt++;
            end else begin
                if (framing_encoding_out !== 1'b0) zviol++;
                if (vcnt > 0) done = 1'b1;
            end
        end
        check({v.name, " frame_done"}, int'(done), 1);
        check({v.name, " latency"}, first, 1);
        check({v.name, " valid_cycles"}, vcnt, v.exp_vld);
        for (int i = 0; i < vcnt && i < exp_len && i < 256; i++) begin
            if (mism < 0 && cap[i] !== expb[i]) mism = i;
        end
        check({v.name, " first_bad_bit_index"}, mism, -1);
        check({v.name, " out_nonzero_while_invalid"}, zviol, 0);
    endtask

    initial begin
        logic [7:0] phr_bits;
        reset_n           = 1'b1;
        phr_psdu_in       = 8'h00;
        phr_psdu_in_valid = 1'b0;

        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", int'(framing_encoding_out_valid), 0);
        check("reset out", int'(framing_encoding_out), 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle out_valid", int'(framing_encoding_out_valid), 0);

        vecs[0] = mk("req026",   8'hFF, 8'h07, 8'h03, 8'h01, 8'h05, 8'h21, 8'h43, 8'h65, 8'h87, 104);
        vecs[1] = mk("len0",     8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 48);
        vecs[2] = mk("phr83",    8'h1F, 8'h83, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 72);
        vecs[3] = mk("underrun", 8'h07, 8'h05, 8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 64);
        vecs[4] = mk("rsvd80",   8'h03, 8'h80, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 48);
        vecs[5] = mk("len2",     8'h0F, 8'h02, 8'hC3, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 64);
        vecs[6] = mk("gap_fill", 8'h21, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h9C, 8'h00, 8'h00, 56);

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i]);
            if (i == 2) begin
                phr_bits = {cap[47], cap[46], cap[45], cap[44], cap[43], cap[42], cap[41], cap[40]};
                check("phr83 phr_byte_on_wire", int'(phr_bits), 'h83);
            end
        end

        // Reset in the middle of the DATA phase, then a fresh frame.
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            phr_psdu_in_valid = (c < 8);
            phr_psdu_in       = (c < 8) ? vecs[0].bytes[8*c +: 8] : 8'h00;
        end
        check("midreset busy_before", int'(framing_encoding_out_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        check("midreset out_valid_async", int'(framing_encoding_out_valid), 0);
        check("midreset out_async", int'(framing_encoding_out), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midreset held_idle", int'(framing_encoding_out_valid), 0);
        reset_n = 1'b1;
        run_frame(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/framing_encoding.md
FRAMING_ENCODING -- requirements
Module: framing_encoding

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk.
REQ-003 phr_psdu_in  input  8  PHR byte (first), then PSDU bytes, one per valid cycle.
REQ-004 phr_psdu_in_valid  input  1  phr_psdu_in carries a byte this cycle; held high for the whole PHR+PSDU burst.
REQ-005 framing_encoding_out  output  1  serial frame bitstream, one bit per clock, registered.
REQ-006 framing_encoding_out_valid  output  1  framing_encoding_out carries a frame bit this cycle, registered.

Function
REQ-007 The frame SHALL be: preamble (32 zero bits), SFD 0xA7, PHR byte, PSDU bytes; every byte is sent LSB first.
REQ-008 The PSDU length SHALL be PHR[6:0] (0..127); PHR[7] is reserved, transmitted unchanged, and does not affect length.
REQ-009 Input bytes SHALL be written into a 128x8 buffer at consecutive addresses starting at 0 on every cycle with valid high, up to 128 bytes; further bytes are dropped.
REQ-010 States SHALL be IDLE, PREAMBLE, SFD, DATA.
REQ-011 IDLE -> PREAMBLE when valid is sampled high; that byte is stored at address 0 (PHR).
REQ-012 First preamble bit SHALL appear with out_valid high on the cycle after the first byte is sampled (latency 1 clock).
REQ-013 PREAMBLE lasts 32 cycles (out=0), SFD lasts 8 cycles (out = 1,1,1,0,0,1,0,1), then DATA.
REQ-014 DATA SHALL serialize bytes 0..PHR[6:0] in order, 8 cycles each, total (PHR[6:0]+1)*8 cycles, then return to IDLE with out_valid low on the next cycle.
REQ-015 Bytes beyond PHR[6:0]+1 received in the same burst SHALL be stored but not transmitted.
REQ-016 Underrun: if DATA needs byte k and fewer than k+1 bytes were written, the frame SHALL abort: out_valid low, out 0, state IDLE.
REQ-017 Valid activity while not IDLE SHALL only fill the current buffer; a new frame starts only from IDLE, when valid is sampled high.
REQ-018 While out_valid is low, framing_encoding_out SHALL be 0.
REQ-019 Returning to IDLE SHALL reset the write pointer to 0, so the next frame starts at address 0.
REQ-020 Length 0 (PHR[6:0]=0) SHALL transmit only preamble, SFD and the PHR byte (48 valid cycles).

Reset
REQ-021 On reset_n low: state IDLE, write pointer 0, bit/byte counters 0, framing_encoding_out 0, framing_encoding_out_valid 0; buffer contents need not be cleared.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately (outputs low asynchronously); the next valid after release starts a fresh frame.

Structure
REQ-023 A shared package SHALL hold PREAMBLE_BITS=32, SFD_BYTE=8'hA7, MAX_FRAME_BYTES=128, LEN_BITS=7 and the state enum.
REQ-024 The 128x8 storage SHALL be one sub-module, framing_buffer, with one write port and one read port, no reset on the array.
REQ-025 The companion framing_decoding block consumes framing_encoding_out; its interface is outside this document.

Verification
REQ-026 Reset pulse, then valid high for 8 cycles with bytes 07,03,01,05,21,43,65,87 -> out_valid high for 104 cycles: 32 zeros, bits 1,1,1,0,0,1,0,1, then 07,03,01,05,21,43,65,87 LSB first.
REQ-027 Single byte 0x00 with valid high 1 cycle -> 48 valid cycles ending in 8 zero bits, then out_valid low.
REQ-028 PHR 0x83 followed by 4 bytes -> PHR sent as bits 1,1,0,0,0,0,0,1; 3 PSDU bytes sent, 4th dropped; 72 valid cycles.
REQ-029 PHR 0x05, valid drops after 3 bytes -> frame aborts when byte 3 is needed (cycle 40+24): out_valid low, state IDLE.
REQ-030 reset_n low during DATA of a frame -> outputs 0 immediately; a new burst after release produces a complete, correct frame.
REQ-031 Loopback into framing_decoding with the REQ-026 stimulus -> decoder emits bytes 07,03,01,05,21,43,65,87 in order.
